// File: rtl/stage_sequencer_pkg.sv
// Shared types for the stage sequencer: FSM state encoding and the
// state-class helpers used by both the FSM and its output decode.
package stage_sequencer_pkg;

    // Eight sequencer states; all encodings of the 3-bit field are used.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEMORY     = 3'd4,
        S_WRITE_BACK = 3'd5,
        S_HALTED     = 3'd6,
        S_FAULT      = 3'd7
    } seq_state_t;

    localparam int STATE_W = 3;

    // A state is "busy" while an instruction is in flight.
    function automatic logic is_busy_state(input seq_state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXECUTE) ||
               (s == S_MEMORY) || (s == S_WRITE_BACK);
    endfunction

    // States that wait on an external ready and are guarded by the timer.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == S_FETCH) || (s == S_MEMORY);
    endfunction

endpackage

// File: rtl/stage_sequencer_wait.sv
// Bounded-wait timer shared by FETCH and MEMORY. Counts cycles spent
// waiting on a ready input and flags expiry on the last allowed cycle
// when ready is still low. TIMEOUT = 0 disables expiry entirely.
module wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic ENABLED = (TIMEOUT > 0);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    // Wait counter: cleared whenever the FSM is not stalled, else counts up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_at_last = (r_cnt == LAST);

    // A ready arriving on the last allowed cycle takes priority over expiry.
    assign expired = ENABLED && count && !ready && w_at_last;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer. Drives one stage enable at a time through
// FETCH, DECODE, EXECUTE, (MEMORY), WRITE_BACK, handles run/halt/resume
// at instruction boundaries, faults on a ready timeout, and keeps
// cycle/retired-instruction counters.
//
// Handshake: fetch_ready and mem_ready are single-cycle completion
// strobes sampled only while the FSM sits in FETCH or MEMORY respectively;
// the stage advances on the clock edge where its ready is seen high.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               halt_req,
    input  logic               resume,
    input  logic               fetch_ready,
    input  logic               mem_access,
    input  logic               mem_ready,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               execute_en,
    output logic               memory_en,
    output logic               write_back_en,
    output logic               pc_update_en,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [WIDTH-1:0]   cycle_count,
    output logic [WIDTH-1:0]   instret_count,
    output logic [STATE_W-1:0] dbg_state
);

    seq_state_t       r_state;
    logic             r_halt_pending;
    logic [WIDTH-1:0] r_cycle_count;
    logic [WIDTH-1:0] r_instret_count;

    logic w_busy;
    logic w_wait_count;
    logic w_wait_ready;
    logic w_wait_clear;
    logic w_expired;

    assign w_busy = is_busy_state(r_state);

    // Stall detection: the timer counts only while a wait state sees no ready.
    // Any other cycle (including the one that leaves the state) clears it, so
    // every entry to FETCH or MEMORY starts from zero.
    assign w_wait_ready = (r_state == S_FETCH) ? fetch_ready : mem_ready;
    assign w_wait_count = is_wait_state(r_state) && !w_wait_ready;
    assign w_wait_clear = !w_wait_count;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_wait_clear),
        .count   (w_wait_count),
        .ready   (w_wait_ready),
        .expired (w_expired)
    );

    // Sequencer FSM with the sticky halt request it consumes at WRITE_BACK.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_halt_pending <= 1'b0;
        end else begin
            // A halt seen mid-instruction is remembered until the boundary.
            if (halt_req && w_busy) begin
                r_halt_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (halt_req) begin
                        r_state <= S_HALTED;
                    end else if (run) begin
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (w_expired) begin
                        r_state <= S_FAULT;
                    end else if (fetch_ready) begin
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    r_state <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    r_state <= mem_access ? S_MEMORY : S_WRITE_BACK;
                end

                S_MEMORY: begin
                    if (w_expired) begin
                        r_state <= S_FAULT;
                    end else if (mem_ready) begin
                        r_state <= S_WRITE_BACK;
                    end
                end

                S_WRITE_BACK: begin
                    if (r_halt_pending || halt_req) begin
                        r_state <= S_HALTED;
                    end else if (!run) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end

                S_HALTED: begin
                    // A simultaneous halt_req keeps the sequencer parked.
                    if (resume && !halt_req) begin
                        r_halt_pending <= 1'b0;
                        r_state        <= run ? S_FETCH : S_IDLE;
                    end
                end

                S_FAULT: begin
                    r_state <= S_FAULT;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Performance counters: active cycles and retirements, free-running wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_count   <= '0;
            r_instret_count <= '0;
        end else begin
            if (w_busy) begin
                r_cycle_count <= r_cycle_count + WIDTH'(1);
            end
            if (r_state == S_WRITE_BACK) begin
                r_instret_count <= r_instret_count + WIDTH'(1);
            end
        end
    end

    // Moore output decode straight from the state register.
    assign fetch_en      = (r_state == S_FETCH);
    assign decode_en     = (r_state == S_DECODE);
    assign execute_en    = (r_state == S_EXECUTE);
    assign memory_en     = (r_state == S_MEMORY);
    assign write_back_en = (r_state == S_WRITE_BACK);
    assign pc_update_en  = (r_state == S_WRITE_BACK);
    assign busy          = w_busy;
    assign halted        = (r_state == S_HALTED);
    assign fault         = (r_state == S_FAULT);
    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
    assign dbg_state     = r_state;

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle control FSM that sequences the core's five stages (fetch, decode, execute, memory, write-back) by driving each stage's `en` input, one stage at a time.
- Waits on fetch and data-memory ready handshakes, with a bounded timeout.
- Skips the memory stage for non-memory instructions.
- Handles run, halt and resume requests at instruction boundaries.
- Maintains cycle and retired-instruction counters.

Parameters:
WIDTH, 32, width of cycle_count and instret_count.
TIMEOUT, 64, maximum wait cycles in FETCH or MEMORY before FAULT; 0 disables the timeout.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  level; 1 = execute instructions.
halt_req  in  1  pulse or level; request to stop at the next instruction boundary.
resume  in  1  pulse; leave HALTED.
fetch_ready  in  1  instruction memory has valid data this cycle.
mem_access  in  1  current instruction uses data memory (from decode); sampled in EXECUTE.
mem_ready  in  1  data memory access completes this cycle.
fetch_en  out  1  enable for the fetch stage.
decode_en  out  1  enable for the decode stage.
execute_en  out  1  enable for the execute stage.
memory_en  out  1  enable for the memory stage.
write_back_en  out  1  enable for the write-back stage.
pc_update_en  out  1  commit the next PC.
busy  out  1  state is not IDLE, HALTED or FAULT.
halted  out  1  state is HALTED.
fault  out  1  state is FAULT.
cycle_count  out  WIDTH  active cycles.
instret_count  out  WIDTH  retired instructions.

Behaviour:
- Reset (asynchronous): state = IDLE, halt_pending = 0, wait_cnt = 0, both counters = 0.
  - All outputs are 0 while reset is high and in the first cycle after release.
- Enables are Moore outputs decoded from the state register.
  - At most one stage enable is high in any cycle.
  - pc_update_en is high exactly when write_back_en is high.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITE_BACK, HALTED, FAULT.
- Transitions:
  - IDLE: run = 1 -> FETCH; otherwise stay.
  - FETCH: fetch_en = 1.
    - fetch_ready = 1 -> DECODE.
    - Otherwise stay and increment wait_cnt.
  - DECODE: decode_en = 1, one cycle -> EXECUTE.
  - EXECUTE: execute_en = 1, one cycle.
    - mem_access = 1 -> MEMORY; otherwise -> WRITE_BACK.
  - MEMORY: memory_en = 1 for every cycle spent here.
    - mem_ready = 1 -> WRITE_BACK.
    - Otherwise stay and increment wait_cnt.
  - WRITE_BACK: write_back_en = 1, one cycle; instret_count += 1. Next state, in priority order:
    1. halt_pending or halt_req -> HALTED.
    2. run = 0 -> IDLE.
    3. Otherwise -> FETCH.
  - HALTED: halted = 1.
    - If resume = 1 and halt_req = 0: clear halt_pending, go to FETCH if run = 1, else IDLE.
    - If halt_req = 1 in the same cycle as resume, halt_req wins: stay in HALTED.
  - FAULT: fault = 1; absorbing; only reset exits.
- wait_cnt: cleared on every entry to FETCH or MEMORY.
  - TIMEOUT > 0: if wait_cnt == TIMEOUT-1 and the ready input is still 0 -> FAULT next cycle. A ready on that same cycle wins and the FSM advances normally.
  - Maximum wait is therefore TIMEOUT cycles in the state.
- halt_pending: set by halt_req in any state other than HALTED, FAULT or IDLE. Cleared on exit from HALTED.
  - halt_req in IDLE goes directly to HALTED, taking priority over run.
- run deasserting mid-instruction never aborts it: the instruction completes through WRITE_BACK, then the FSM goes to IDLE.
- cycle_count increments every cycle that busy = 1.
- Both counters wrap modulo 2^WIDTH with no saturation.
- Reset mid-instruction abandons the instruction. The stage registers themselves are not cleared by this block.
- Latency per instruction:
  - Non-memory instruction: 4 cycles plus fetch wait.
  - Memory instruction: 5 cycles plus fetch wait plus memory wait.

Decomposition:
- Shared package (params.sv): seq_state_t enum holding the eight states.
- Sub-module wait_timer (parameter TIMEOUT):
  - Inputs: clear, count, ready.
  - Output: expired.
  - Instantiated once and shared by FETCH and MEMORY.
- Counters and the FSM live in stage_sequencer.

Test Plan:
- Reset, run = 1, fetch_ready = 1, mem_access = 0 -> FETCH, DECODE, EXECUTE, WRITE_BACK over 4 cycles; instret_count = 1, cycle_count = 4; next state is FETCH.
- mem_access = 1, mem_ready low 3 cycles then high -> memory_en high for 4 cycles; write_back_en one cycle later; instret_count increments by 1.
- TIMEOUT = 4, fetch_ready held 0 -> fetch_en high 4 cycles, then fault = 1 permanently; counters frozen; reset clears all state.
- halt_req pulsed during DECODE -> instruction completes WRITE_BACK, then halted = 1. resume pulse -> FETCH next cycle. resume and halt_req together -> stays HALTED.
- run dropped during EXECUTE -> WRITE_BACK completes, then IDLE with busy = 0. Asynchronous reset asserted mid-MEMORY -> all outputs 0 immediately, without waiting for a clock edge.
- WIDTH = 4, run 16 non-memory instructions -> instret_count wraps to 0; cycle_count = 64 mod 16 = 0.
